// File: rtl/antirrebote_botones_pkg.sv
// Shared types and default timing for the push-button input stage.
// Default counts assume a 100 MHz clock.
package botones_pkg;

    typedef enum logic [2:0] {
        REPOSO,
        FILTRO_P,
        PULSADO,
        REPETICION,
        FILTRO_S
    } estado_boton_t;

    localparam int T_ANTIRREBOTE = 1_000_000;   // 10 ms
    localparam int T_RETARDO_REP = 50_000_000;  // 500 ms
    localparam int T_PERIODO_REP = 10_000_000;  // 100 ms

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/antirrebote_botones_if.sv
// Button-side bus: raw buttons in, count pulses and debounced levels out.
interface botones_if;
    logic       S;
    logic       B;
    logic [1:0] sb;
    logic [1:0] niveles;

    modport master (output S, output B, input sb, input niveles);
    modport slave  (input S, input B, output sb, output niveles);
endinterface

// File: rtl/antirrebote_botones_canal.sv
// One button channel: 2-FF synchronizer, shared debounce/repeat counter and FSM.
// pulso and nivel are next-cycle values; the top registers them.
module canal_antirrebote
    import botones_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = T_ANTIRREBOTE,
    parameter int REPEAT_DELAY    = T_RETARDO_REP,
    parameter int REPEAT_PERIOD   = T_PERIODO_REP
) (
    input  logic clk,
    input  logic rst,
    input  logic boton,
    output logic pulso,
    output logic nivel
);
    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] FIN_D = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] FIN_R = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] FIN_P = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    sinc;
    logic          x;
    estado_boton_t estado, estado_sig;
    logic [CW-1:0] cnt, cnt_sig;

    assign x = sinc[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sinc   <= 2'b00;
            estado <= REPOSO;
            cnt    <= '0;
        end else begin
            sinc   <= {sinc[0], boton};
            estado <= estado_sig;
            cnt    <= cnt_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        cnt_sig    = cnt;
        pulso      = 1'b0;
        case (estado)
            REPOSO:
                if (x) begin
                    estado_sig = FILTRO_P;
                    cnt_sig    = '0;
                end
            FILTRO_P:
                if (!x) estado_sig = REPOSO;
                else if (cnt == FIN_D) begin
                    estado_sig = PULSADO;
                    pulso      = 1'b1;
                    cnt_sig    = '0;
                end else cnt_sig = cnt + CW'(1);
            PULSADO:
                if (!x) begin
                    estado_sig = FILTRO_S;
                    cnt_sig    = '0;
                end else if (cnt == FIN_R) begin
                    estado_sig = REPETICION;
                    pulso      = 1'b1;
                    cnt_sig    = '0;
                end else cnt_sig = cnt + CW'(1);
            REPETICION:
                if (!x) begin
                    estado_sig = FILTRO_S;
                    cnt_sig    = '0;
                end else if (cnt == FIN_P) begin
                    pulso   = 1'b1;
                    cnt_sig = '0;
                end else cnt_sig = cnt + CW'(1);
            FILTRO_S:
                // A bounce back high restarts the repeat delay without a new pulse.
                if (x) begin
                    estado_sig = PULSADO;
                    cnt_sig    = '0;
                end else if (cnt == FIN_D) estado_sig = REPOSO;
                else cnt_sig = cnt + CW'(1);
            default: begin
                estado_sig = REPOSO;
                cnt_sig    = '0;
            end
        endcase
        nivel = (estado_sig == PULSADO) || (estado_sig == REPETICION) ||
                (estado_sig == FILTRO_S);
    end

endmodule

// File: rtl/antirrebote_botones.sv
// Two debounced button channels (S = up, B = down) feeding registered
// count pulses; simultaneous pulses cancel so sb never reads 2'b11.
module antirrebote_botones
    import botones_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = T_ANTIRREBOTE,
    parameter int REPEAT_DELAY    = T_RETARDO_REP,
    parameter int REPEAT_PERIOD   = T_PERIODO_REP
) (
    input  logic     clk,
    input  logic     rst,
    botones_if.slave bus
);
    logic [1:0] boton, pulso, nivel;
    logic [1:0] sb_q, niveles_q;

    assign boton = {bus.S, bus.B};

    for (genvar i = 0; i < 2; i++) begin : g_canal
        canal_antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_canal (
            .clk  (clk),
            .rst  (rst),
            .boton(boton[i]),
            .pulso(pulso[i]),
            .nivel(nivel[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q      <= 2'b00;
            niveles_q <= 2'b00;
        end else begin
            sb_q      <= (&pulso) ? 2'b00 : pulso;
            niveles_q <= nivel;
        end
    end

    assign bus.sb      = sb_q;
    assign bus.niveles = niveles_q;

endmodule
